// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: hex glyph table, digit count, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Active-high segment codes, bit 0 = a ... bit 6 = g, indexed by hex value.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg_glyph_lut.sv
// Combinational reverse lookup of an active-high 7-segment glyph into a hex nibble.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; o_hit=0 and o_nibble=0 for any pattern that is not a hex glyph.
//
// Ports: i_glyph  - active-high segments g..a
//        o_hit    - pattern matches one of the 16 hex glyphs
//        o_nibble - decoded value (0 on miss)
module seg_glyph_lut
    import seg_pkg::*;
(
    input  logic [6:0] i_glyph,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_glyph == HEX_GLYPH[i]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 8-digit hex word shown by a multiplexed 7-segment driver from its AN/SEG scan.
// Latency: last digit's first stable registered sample -> value_valid in STABLE_CYCLES+1 clocks.
// Backpressure: frame held until value_ready; a frame completing while one is pending is dropped (overrun, sticky).
//
// Ports: clk, rst (async, active-low); AN/SEG active-low scan inputs (SEG[7] = dp);
//        value/glyph_err/dp frame outputs with value_valid/value_ready handshake; overrun sticky flag.
// Build option: SEG_DP_CAPTURE_EN stores the decimal points per digit and includes SEG[7] in the
//        stability compare; without it dp reads 8'h00 and SEG[7] is ignored.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,   // >= 2
    parameter int CNT_W         = 3    // must hold STABLE_CYCLES-1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [7:0]  SEG,
    output logic [31:0] value,
    output logic        value_valid,
    input  logic        value_ready,
    output logic        glyph_err,
    output logic        overrun,
    output logic [7:0]  dp
);

`ifdef SEG_DP_CAPTURE_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
    logic w_unused_dp;
    assign w_unused_dp = SEG[7];
`endif

    logic [7:0]       r_an_q, r_an_p;
    logic [SW-1:0]    r_seg_q, r_seg_p;
    scan_state_t      r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [7:0]       r_mask;
    logic             r_err;
    logic [31:0]      r_digits;

    logic [7:0]       w_an_lo;
    logic             w_scan_vld;
    logic [IDX_W-1:0] w_idx;
    logic             w_same;
    logic             w_cap;
    logic             w_hit;
    logic [3:0]       w_nib;
    logic             w_complete;
    logic [7:0]       w_cap_bit;

    // A scan is valid only when exactly one anode is pulled low.
    assign w_an_lo    = ~r_an_q;
    assign w_scan_vld = (w_an_lo != 8'h00) && ((w_an_lo & (w_an_lo - 8'd1)) == 8'h00);
    assign w_same     = (r_an_q == r_an_p) && (r_seg_q == r_seg_p);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    seg_glyph_lut u_lut (
        .i_glyph  (~r_seg_q[6:0]),
        .o_hit    (w_hit),
        .o_nibble (w_nib)
    );

    // r_cnt counts matching back-to-back samples; the digit is taken on the compare that
    // brings it to STABLE_CYCLES-1, i.e. once STABLE_CYCLES identical samples have been seen.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cap     = 1'b0;
        case (r_state)
            WAIT: begin
                if (w_scan_vld) begin
                    w_state_n = SETTLE;
                    w_cnt_n   = '0;
                end
            end
            SETTLE: begin
                if (!w_same) begin
                    w_cnt_n = '0;
                    if (!w_scan_vld) begin
                        w_state_n = WAIT;
                    end
                end else if (r_cnt == CNT_W'(STABLE_CYCLES - 2)) begin
                    w_cap     = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = HELD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            HELD: begin
                // Leaving a dwell is handled exactly like WAIT seeing the new sample.
                if (!w_same) begin
                    w_cnt_n   = '0;
                    w_state_n = w_scan_vld ? SETTLE : WAIT;
                end
            end
            default: begin
                w_state_n = WAIT;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign w_complete = (r_mask == 8'hFF);
    assign w_cap_bit  = w_cap ? (8'd1 << w_idx) : 8'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an_q   <= '1;
            r_an_p   <= '1;
            r_seg_q  <= '1;
            r_seg_p  <= '1;
            r_state  <= WAIT;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_err    <= 1'b0;
            r_digits <= '0;
        end else begin
            r_an_q  <= AN;
            r_seg_q <= SEG[SW-1:0];
            r_an_p  <= r_an_q;
            r_seg_p <= r_seg_q;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            // A completed frame restarts the mask; a capture in the same cycle belongs to the next frame.
            r_mask  <= (w_complete ? 8'h00 : r_mask) | w_cap_bit;
            r_err   <= (w_complete ? 1'b0 : r_err) | (w_cap & ~w_hit);
            if (w_cap) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_hit ? w_nib : 4'h0;
            end
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic [7:0] r_dp_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_store <= '0;
            dp         <= '0;
        end else begin
            if (w_cap) begin
                r_dp_store[w_idx] <= ~r_seg_q[7];
            end
            if (w_complete && (!value_valid || value_ready)) begin
                dp <= r_dp_store;
            end
        end
    end
`else
    assign dp = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value       <= '0;
            value_valid <= 1'b0;
            glyph_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!value_valid || value_ready) begin
                    value       <= r_digits;
                    glyph_err   <= r_err;
                    value_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (value_valid && value_ready) begin
                value_valid <= 1'b0;
            end
        end
    end

endmodule
